// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the uRISC pipeline sequencer: FSM states, next-PC select codes
// and the in-flight scoreboard entry layout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXC    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_TGT = 2'd1;
  localparam logic [1:0] PC_EXC = 2'd2;
  localparam logic [1:0] PC_EPC = 2'd3;

  // Destination is stored zero-extended so one struct serves any REG_AW up to this width.
  localparam int SB_DEST_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination scoreboard: shift register of writers between ID issue and
// register-file write, plus rs/rt RAW match. PIPE_CTRL_FORWARD_EN limits matches to load-use.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_en,
  input  logic [REG_AW-1:0] ins_dest,
  input  logic              ins_load,
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] rt,
  input  logic              rt_used,
  output logic              hazard,
  output logic              any_valid
);

  sb_entry_t sb_q [PIPE_DEPTH];
  sb_entry_t sb_d [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] valid_vec;
  logic [PIPE_DEPTH-1:0] load_vec;
  logic [PIPE_DEPTH-1:0] rs_hit;
  logic [PIPE_DEPTH-1:0] rt_hit;
  logic [PIPE_DEPTH-1:0] qual;

  always_comb begin
    sb_d[0] = '0;
    if (ins_en) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].dest    = SB_DEST_W'(ins_dest);
      sb_d[0].is_load = ins_load;
    end
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_match
      assign valid_vec[gi] = sb_q[gi].valid;
      assign load_vec[gi]  = sb_q[gi].is_load;
      assign rs_hit[gi]    = sb_q[gi].valid & rs_used & (sb_q[gi].dest == SB_DEST_W'(rs));
      assign rt_hit[gi]    = sb_q[gi].valid & rt_used & (sb_q[gi].dest == SB_DEST_W'(rt));
    end
  endgenerate

`ifdef PIPE_CTRL_FORWARD_EN
  // With the IX/MEM bypass only a load still sitting in IX cannot forward in time.
  assign qual = load_vec & PIPE_DEPTH'(1);
`else
  logic unused_load;
  assign qual        = '1;
  assign unused_load = ^load_vec;
`endif

  assign hazard    = |((rs_hit | rt_hit) & qual);
  assign any_valid = |valid_vec;

endmodule

// File: rtl/pipe_ctrl.sv
// uRISC pipeline sequencer: stall/flush/bubble, next-PC select, EPC capture and halt.
// Optional build macro PIPE_CTRL_FORWARD_EN: only load-use dependencies stall.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_p1,
  input  logic [REG_AW-1:0] rs_id_p1,
  input  logic [REG_AW-1:0] rt_id_p1,
  input  logic              rs_used_p1,
  input  logic              rt_used_p1,
  input  logic [REG_AW-1:0] dest_reg_id_p1,
  input  logic              reg_write_valid_id_p1,
  input  logic              load_id_p1,
  input  logic              halt_idif_p1,
  input  logic              illegal_op_idif_p1,
  input  logic              return_execution_idif_p1,
  input  logic              redirect_ix_p1,
  output logic              stall_if_p1,
  output logic              flush_id_p1,
  output logic              bubble_ix_p1,
  output logic [1:0]        pc_sel_p1,
  output logic              epc_we_p1,
  output logic              halted_p1
);

  state_t state_q, state_d;
  logic   ins_en;
  logic   sb_hazard;
  logic   sb_any_valid;
  logic   hazard;

  pipe_scoreboard #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .REG_AW    (REG_AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .ins_en   (ins_en),
    .ins_dest (dest_reg_id_p1),
    .ins_load (load_id_p1),
    .rs       (rs_id_p1),
    .rs_used  (rs_used_p1),
    .rt       (rt_id_p1),
    .rt_used  (rt_used_p1),
    .hazard   (sb_hazard),
    .any_valid(sb_any_valid)
  );

  // Bubbles in ID carry stale register fields, so they never count as readers.
  assign hazard = id_valid_p1 & sb_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ins_en       = 1'b0;
    stall_if_p1  = 1'b0;
    flush_id_p1  = 1'b0;
    bubble_ix_p1 = 1'b0;
    pc_sel_p1    = PC_SEQ;
    epc_we_p1    = 1'b0;
    halted_p1    = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_ix_p1) begin
          pc_sel_p1   = PC_TGT;
          flush_id_p1 = 1'b1;
        end else if (illegal_op_idif_p1) begin
          pc_sel_p1   = PC_EXC;
          epc_we_p1   = 1'b1;
          flush_id_p1 = 1'b1;
          state_d     = EXC;
        end else if (return_execution_idif_p1) begin
          pc_sel_p1   = PC_EPC;
          flush_id_p1 = 1'b1;
        end else if (hazard) begin
          stall_if_p1  = 1'b1;
          bubble_ix_p1 = 1'b1;
        end else begin
          ins_en = id_valid_p1 & reg_write_valid_id_p1;
          if (halt_idif_p1) state_d = DRAIN;
        end
      end
      // Exception flags are ignored here so a repeated illegal op cannot recapture EPC.
      EXC: begin
        state_d = RUN;
        if (redirect_ix_p1) begin
          pc_sel_p1   = PC_TGT;
          flush_id_p1 = 1'b1;
        end else if (hazard) begin
          stall_if_p1  = 1'b1;
          bubble_ix_p1 = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect_ix_p1) begin
          pc_sel_p1   = PC_TGT;
          flush_id_p1 = 1'b1;
          state_d     = RUN;
        end else begin
          stall_if_p1  = 1'b1;
          bubble_ix_p1 = 1'b1;
          if (!sb_any_valid) state_d = HALTED;
        end
      end
      HALTED: begin
        stall_if_p1 = 1'b1;
        halted_p1   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default PIPE_DEPTH=3, REG_AW=3).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, rs_used, rt_used, wr, ld;
  logic [2:0] rs, rt, dest;
  logic       halt, illegal, rti, redirect;
  logic       stall, flush, bubble, epc_we, halted;
  logic [1:0] pc_sel;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_FORWARD_EN
  localparam int EXP_LD  = 1;
  localparam int EXP_ALU = 0;
`else
  localparam int EXP_LD  = 3;
  localparam int EXP_ALU = 3;
`endif

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .id_valid_p1             (id_valid),
    .rs_id_p1                (rs),
    .rt_id_p1                (rt),
    .rs_used_p1              (rs_used),
    .rt_used_p1              (rt_used),
    .dest_reg_id_p1          (dest),
    .reg_write_valid_id_p1   (wr),
    .load_id_p1              (ld),
    .halt_idif_p1            (halt),
    .illegal_op_idif_p1      (illegal),
    .return_execution_idif_p1(rti),
    .redirect_ix_p1          (redirect),
    .stall_if_p1             (stall),
    .flush_id_p1             (flush),
    .bubble_ix_p1            (bubble),
    .pc_sel_p1               (pc_sel),
    .epc_we_p1               (epc_we),
    .halted_p1               (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-28s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; rs = 0; rt = 0; rs_used = 0; rt_used = 0;
    dest = 0; wr = 0; ld = 0;
    halt = 0; illegal = 0; rti = 0; redirect = 0;
  endtask

  task automatic instr(input logic [2:0] a_rs, input logic a_rsu, input logic [2:0] a_rt,
                       input logic a_rtu, input logic [2:0] a_d, input logic a_wr, input logic a_ld);
    id_valid = 1; rs = a_rs; rs_used = a_rsu; rt = a_rt; rt_used = a_rtu;
    dest = a_d; wr = a_wr; ld = a_ld;
  endtask

  // Counts consecutive stalled cycles of the instruction held in ID, bounded at 10.
  task automatic count_stall(input string tag, input int exp);
    int n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (stall !== 1'b1) break;
      chk({tag, "_bubble"}, bubble, 1);
      n++;
      nxt();
    end
    chk(tag, n, exp);
  endtask

  initial begin
    rst = 1;
    idle();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_epc_we", epc_we, 0);
    chk("rst_halted", halted, 0);
    #5 rst = 0;
    nxt();

    // LD r2 then a reader of rt=2
    instr(3'd0, 0, 3'd0, 0, 3'd2, 1, 1);
    #1; chk("ld_issue_stall", stall, 0);
    nxt();
    instr(3'd0, 0, 3'd2, 1, 3'd4, 0, 0);
    count_stall("ld_use_stalls", EXP_LD);
    nxt(); idle(); repeat (4) nxt();

    // ADD r3 then a reader of rs=3
    instr(3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
    nxt();
    instr(3'd3, 1, 3'd0, 0, 3'd5, 0, 0);
    count_stall("alu_raw_stalls", EXP_ALU);
    nxt(); idle(); repeat (4) nxt();

    // A bubble in ID never raises a hazard
    instr(3'd0, 0, 3'd0, 0, 3'd6, 1, 1);
    nxt();
    instr(3'd6, 1, 3'd6, 1, 3'd0, 0, 0);
    id_valid = 0;
    #1; chk("nop_no_stall", stall, 0);
    chk("nop_no_bubble", bubble, 0);
    nxt(); idle(); repeat (4) nxt();

    // Redirect during a hazard stall; the held writer of r5 must not be recorded
    instr(3'd0, 0, 3'd0, 0, 3'd1, 1, 1);
    nxt();
    instr(3'd1, 1, 3'd0, 0, 3'd5, 1, 0);
    #1; chk("pre_redirect_stall", stall, 1);
    nxt();
    redirect = 1;
    #1; chk("redir_pc_sel", pc_sel, 1);
    chk("redir_flush", flush, 1);
    chk("redir_stall", stall, 0);
    chk("redir_bubble", bubble, 0);
    nxt();
    redirect = 0;
    instr(3'd5, 1, 3'd0, 0, 3'd0, 0, 0);
    #1; chk("redir_dest_absent", stall, 0);
    nxt(); idle(); repeat (4) nxt();

    // Illegal op, repeated illegal op, then RTI
    illegal = 1;
    #1; chk("exc_epc_we", epc_we, 1);
    chk("exc_pc_sel", pc_sel, 2);
    chk("exc_flush", flush, 1);
    nxt();
    #1; chk("exc_second_epc_we", epc_we, 0);
    chk("exc_second_pc_sel", pc_sel, 0);
    nxt();
    illegal = 0; rti = 1;
    #1; chk("rti_pc_sel", pc_sel, 3);
    chk("rti_flush", flush, 1);
    chk("rti_epc_we", epc_we, 0);
    nxt();
    rti = 0; redirect = 1; illegal = 1;
    #1; chk("prio_pc_sel", pc_sel, 1);
    chk("prio_epc_we", epc_we, 0);
    nxt();
    redirect = 0;
    #1; chk("post_prio_epc_we", epc_we, 1);
    nxt();
    illegal = 0;
    nxt();

    // HALT with two writers in flight (r2 at entry 1, r1 at entry 2)
    instr(3'd0, 0, 3'd0, 0, 3'd1, 1, 0);
    nxt();
    instr(3'd0, 0, 3'd0, 0, 3'd2, 1, 0);
    nxt();
    idle();
    nxt();
    halt = 1;
    #1; chk("halt_decode_stall", stall, 0);
    nxt();
    halt = 0;
    #1; chk("drain1_stall", stall, 1);
    chk("drain1_bubble", bubble, 1);
    chk("drain1_halted", halted, 0);
    nxt();
    #1; chk("drain2_stall", stall, 1);
    chk("drain2_halted", halted, 0);
    nxt();
    #1; chk("halted", halted, 1);
    chk("halted_stall", stall, 1);
    nxt();
    redirect = 1;
    #1; chk("halted_sticky", halted, 1);
    chk("halted_ignores_redir", pc_sel, 0);
    redirect = 0;
    #1 rst = 1;
    #1; chk("async_rst_halted", halted, 0);
    chk("async_rst_stall", stall, 0);
    #1 rst = 0;
    nxt();

    // HALT cancelled by a redirect on the next cycle
    halt = 1;
    nxt();
    halt = 0; redirect = 1;
    #1; chk("cancel_pc_sel", pc_sel, 1);
    chk("cancel_flush", flush, 1);
    chk("cancel_stall", stall, 0);
    nxt();
    redirect = 0;
    #1; chk("cancel_run_stall", stall, 0);
    chk("cancel_halted", halted, 0);
    nxt(); nxt();
    #1; chk("cancel_halted_late", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
